// File: rtl/vending_fsm_param_if.sv
// ---------------------------------------------------------------------------
// vending_fsm_param_if
//   Bundles the coin-acceptor / product-select / dispenser signals of the
//   parametrised vending controller.
//
//   master : front end + dispenser drivers (drives x, vend, sel, cancel)
//   slave  : the vending controller
//
//   x            coin code 00 none, 01/10/11 = COIN1/2/3
//   vend, sel    purchase request and product index
//   cancel       refund request
//   z, item      one-cycle vend pulse and vended product index
//   change       coin code dispensed this cycle
//   deny         one-cycle purchase-refused pulse
//   coin_reject  one-cycle coin-returned pulse
//   busy         controller is vending or paying out change
//   credit       current credit
//   sold_out     per-item stock-empty flags (only with VM_STOCK_EN)
//
//   Optional feature macro: VM_STOCK_EN
// ---------------------------------------------------------------------------
interface vending_fsm_param_if #(
    parameter int CREDIT_W = 8,
    parameter int SEL_W    = 2
`ifdef VM_STOCK_EN
    , parameter int NUM_ITEMS = 4
`endif
);
    logic [1:0]          x;
    logic                vend;
    logic [SEL_W-1:0]    sel;
    logic                cancel;
    logic                z;
    logic [SEL_W-1:0]    item;
    logic [1:0]          change;
    logic                deny;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
`ifdef VM_STOCK_EN
    logic [NUM_ITEMS-1:0] sold_out;

    modport master (
        output x, vend, sel, cancel,
        input  z, item, change, deny, coin_reject, busy, credit, sold_out
    );
    modport slave (
        input  x, vend, sel, cancel,
        output z, item, change, deny, coin_reject, busy, credit, sold_out
    );
`else
    modport master (
        output x, vend, sel, cancel,
        input  z, item, change, deny, coin_reject, busy, credit
    );
    modport slave (
        input  x, vend, sel, cancel,
        output z, item, change, deny, coin_reject, busy, credit
    );
`endif
endinterface

// File: rtl/vending_fsm_param.sv
// ---------------------------------------------------------------------------
// vending_fsm_param
//   Multi-product vending controller. Accumulates coin credit up to
//   MAX_CREDIT, sells one of NUM_ITEMS products at parameter prices, and pays
//   change back one coin per cycle, largest denomination first. Cancel
//   refunds the whole credit through the same change sequencer.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   vending_fsm_param_if.slave (coin/select inputs, vend/change/
//           deny/coin_reject/busy/credit outputs, sold_out with stock)
//
//   All outputs are registered. States: IDLE, VEND (one cycle), CHANGE.
//
//   Optional feature macro: VM_STOCK_EN -- per-item stock counters loaded
//   with STOCK_INIT, sold-out items are denied, sold_out flags exported.
// ---------------------------------------------------------------------------
module vending_fsm_param #(
    parameter int CREDIT_W  = 8,
    parameter int NUM_ITEMS = 4,
    parameter int SEL_W     = 2,
    parameter int COIN1_VAL = 5,
    parameter int COIN2_VAL = 10,
    parameter int COIN3_VAL = 25,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd35, 8'd25, 8'd20, 8'd15},
    parameter int MAX_CREDIT = 100
`ifdef VM_STOCK_EN
    , parameter int STOCK_INIT = 3
`endif
) (
    input logic clk,
    input logic rst,
    vending_fsm_param_if.slave bus
);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam int NSEL = 2**SEL_W;
    localparam logic [CREDIT_W-1:0] C1   = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] C2   = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] C3   = CREDIT_W'(COIN3_VAL);
    localparam logic [CREDIT_W:0]   CMAX = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic                z_q;
    logic [SEL_W-1:0]    item_q;
    logic [1:0]          change_q;
    logic                deny_q;
    logic                rej_q;
    logic                busy_q;

    // Lookup tables padded to the full select range so an out-of-range sel
    // simply reads "invalid" instead of indexing past the item list.
    logic [CREDIT_W-1:0] price_tab [NSEL];
    logic [NSEL-1:0]     sel_valid;
    logic [NSEL-1:0]     in_stock;

    for (genvar i = 0; i < NSEL; i++) begin : g_tab
        if (i < NUM_ITEMS) begin : g_item
            assign price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
            assign sel_valid[i] = 1'b1;
        end else begin : g_pad
            assign price_tab[i] = '0;
            assign sel_valid[i] = 1'b0;
        end
    end

    // Coin decode; the sum carries one extra bit so the ceiling check sees
    // the true total rather than a wrapped one.
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_in;
    logic [CREDIT_W-1:0] price;
    logic                vend_ok;
    logic                vend_fire;

    always_comb begin
        case (bus.x)
            2'b01:   coin_val = (CREDIT_W+1)'(COIN1_VAL);
            2'b10:   coin_val = (CREDIT_W+1)'(COIN2_VAL);
            2'b11:   coin_val = (CREDIT_W+1)'(COIN3_VAL);
            default: coin_val = '0;
        endcase
    end

    assign coin_in   = (bus.x != 2'b00);
    assign coin_sum  = {1'b0, credit_q} + coin_val;
    assign price     = price_tab[bus.sel];
    assign vend_ok   = sel_valid[bus.sel] && (credit_q >= price) && in_stock[bus.sel];
    // cancel outranks vend, so a vend only fires when cancel is low
    assign vend_fire = (state == IDLE) && !bus.cancel && bus.vend && vend_ok;

`ifdef VM_STOCK_EN
    localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [NUM_ITEMS-1:0] sold_q;

    for (genvar i = 0; i < NSEL; i++) begin : g_stock
        if (i < NUM_ITEMS) begin : g_cnt
            logic [STOCK_W-1:0] cnt;
            logic               so;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= STOCK_W'(STOCK_INIT);
                    so  <= (STOCK_INIT == 0);
                end else if (vend_fire && (bus.sel == SEL_W'(i))) begin
                    cnt <= cnt - STOCK_W'(1);
                    so  <= (cnt == STOCK_W'(1));
                end
            end
            assign in_stock[i] = (cnt != '0);
            assign sold_q[i]   = so;
        end else begin : g_pad
            assign in_stock[i] = 1'b0;
        end
    end

    assign bus.sold_out = sold_q;
`else
    assign in_stock = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            credit_q <= '0;
            z_q      <= 1'b0;
            item_q   <= '0;
            change_q <= 2'b00;
            deny_q   <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // pulse outputs default low every cycle
            z_q      <= 1'b0;
            item_q   <= '0;
            change_q <= 2'b00;
            deny_q   <= 1'b0;
            rej_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cancel) begin
                        rej_q <= coin_in;
                        if (credit_q != '0) begin
                            state  <= CHANGE;
                            busy_q <= 1'b1;
                        end
                    end else if (bus.vend) begin
                        rej_q <= coin_in;
                        if (vend_ok) begin
                            state    <= VEND;
                            busy_q   <= 1'b1;
                            z_q      <= 1'b1;
                            item_q   <= bus.sel;
                            credit_q <= credit_q - price;
                        end else begin
                            deny_q <= 1'b1;
                        end
                    end else if (coin_in) begin
                        if (coin_sum <= CMAX) credit_q <= coin_sum[CREDIT_W-1:0];
                        else                  rej_q    <= 1'b1;
                    end
                end
                VEND: begin
                    rej_q <= coin_in;
                    if (credit_q != '0) begin
                        state <= CHANGE;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                CHANGE: begin
                    rej_q <= coin_in;
                    if (credit_q >= C3) begin
                        change_q <= 2'b11;
                        credit_q <= credit_q - C3;
                    end else if (credit_q >= C2) begin
                        change_q <= 2'b10;
                        credit_q <= credit_q - C2;
                    end else if (credit_q >= C1) begin
                        change_q <= 2'b01;
                        credit_q <= credit_q - C1;
                    end else begin
                        // empty (or sub-coin residue): drop it and go idle
                        credit_q <= '0;
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.z           = z_q;
    assign bus.item        = item_q;
    assign bus.change      = change_q;
    assign bus.deny        = deny_q;
    assign bus.coin_reject = rej_q;
    assign bus.busy        = busy_q;
    assign bus.credit      = credit_q;

endmodule

// File: doc/vending_fsm_param.md
Name: vending_fsm_param

Overview:
Parametrised successor to the single-product vending controller. Accepts 2-bit coded coins, holds a running credit, sells one of NUM_ITEMS products at per-item parameter prices, and returns change serially, one coin per cycle, largest denomination first. Adds cancel/refund, an overpay limit, a deny indication and a change sequencer. Sits between the coin-acceptor front end and the product/coin dispenser drivers.

Parameters:
CREDIT_W, 8, credit register width in bits
NUM_ITEMS, 4, number of selectable products (>=2)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_ITEMS
COIN1_VAL, 5, value of coin code 01
COIN2_VAL, 10, value of coin code 10
COIN3_VAL, 25, value of coin code 11; COIN1<COIN2<COIN3
PRICES, {8'd35,8'd25,8'd20,8'd15}, flat NUM_ITEMS*CREDIT_W vector; item i at bits [i*CREDIT_W +: CREDIT_W]; each price a multiple of COIN1_VAL
MAX_CREDIT, 100, credit ceiling; must be < 2**CREDIT_W
STOCK_INIT, 3, per-item initial stock (used only with VM_STOCK_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
x  in  2  coin code: 00 none, 01/10/11 = COIN1/2/3; sampled every rising edge
vend  in  1  purchase request, level sampled per cycle
sel  in  SEL_W  product index, valid with vend
cancel  in  1  refund request
z  out  1  one-cycle vend pulse
item  out  SEL_W  index of the product vended; valid while z=1, else 0
change  out  2  coin code dispensed this cycle (00 = none)
deny  out  1  one-cycle pulse: insufficient credit, invalid sel, or sold out
coin_reject  out  1  one-cycle pulse: coin not accepted, physically returned
busy  out  1  high in VEND and CHANGE states
credit  out  CREDIT_W  current credit

Behaviour:
- Reset (async, rst=1): state IDLE; credit=0; z, item, change, deny, coin_reject = 0; stock counters = STOCK_INIT.
- All outputs are registered; each response appears the cycle after the sampling edge.
- States: IDLE, VEND, CHANGE.
- IDLE priority, evaluated per edge: cancel > vend > coin.
  - cancel with credit>0 -> CHANGE, refund = full credit. cancel with credit=0 -> no effect.
  - vend with sel<NUM_ITEMS and credit>=PRICES[sel] (and stock>0 if enabled) -> VEND, credit -= price.
  - Any other vend -> deny=1 for one cycle; stay IDLE; credit unchanged.
  - Coin present while cancel or vend is processed that cycle -> coin_reject=1; coin not credited.
  - Coin alone: if credit+value <= MAX_CREDIT, credit += value; else coin_reject=1 and credit unchanged.
  - Compute the sum at CREDIT_W+1 bits; the credit register never wraps.
- VEND (one cycle): z=1, item=sel latched at request. Next state CHANGE if remaining credit>0, else IDLE.
- CHANGE, one coin per cycle, greedy:
  - credit>=COIN3 -> change=11, credit -= COIN3.
  - else credit>=COIN2 -> change=10, credit -= COIN2.
  - else credit>=COIN1 -> change=01, credit -= COIN1.
  - credit=0 -> change=00 and return to IDLE, so one idle cycle follows the last coin.
  - A residue below COIN1 is cleared to 0.
- In VEND/CHANGE: vend and cancel are ignored (no deny); any coin -> coin_reject=1.
- Reset mid-vend or mid-change aborts immediately; undispensed change is lost.

Optional Feature:
VM_STOCK_EN
- Defined: per-item stock counters of width clog2(STOCK_INIT+1), loaded with STOCK_INIT at reset and decremented on each VEND. Vend of an item with stock=0 -> deny. Extra output sold_out [NUM_ITEMS-1:0], registered, bit i = (stock_i==0).
- Undefined: unlimited stock, no counters, no sold_out port.

Test Plan:
1. Assert rst mid-run while busy=1 -> all outputs 0 and credit=0 the same cycle, without waiting for a clock edge; state returns to IDLE.
2. x=01, then x=10 (credit 15), then vend sel=0 -> z=1 and item=0 for one cycle; change stays 00; credit=0; busy drops 2 cycles after VEND.
3. x=11 (25), then vend sel=0 (15) -> z pulse, then change=10 for one cycle, then 00; credit ends at 0.
4. x=01 (5), then vend sel=1 (price 20) -> deny=1 for one cycle, credit remains 5. Then vend sel=3 with 35 credited -> z, item=3.
5. Credit 40 (x=11, x=10, x=01), then cancel -> change sequence 11, 10, 01, 00; credit 0; no z. Coin x=10 during CHANGE -> coin_reject=1, credit unaffected.
6. Credit 100, then x=01 -> coin_reject=1, credit stays 100. Simultaneous vend+coin in IDLE -> coin_reject=1 and the vend is processed. With VM_STOCK_EN and STOCK_INIT=1: two funded vends of sel=2 -> first z=1, second deny=1, sold_out[2]=1.
